// File: rtl/power_sequencer.sv
// power_sequencer: ordered rail power-up/down with per-rail pgood timeout and sticky fault capture.
// Define POWER_SEQUENCER_PGOOD_DEBOUNCE_EN to synchronize and debounce pgood_bus.
module power_sequencer #(
  parameter int NumConverters = 8,
  parameter int TimeoutCycles = 1000,
  parameter int StepDelayCycles = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic        clr_fault,
  input  logic        fault_in,
  input  logic [31:0] pgood_bus,
  output logic [31:0] en,
  output logic        busy,
  output logic        seq_done,
  output logic        seq_fault,
  output logic [4:0]  fault_rail,
  output logic [1:0]  fault_cause
);
  localparam logic [31:0] rail_mask = 32'((64'd1 << NumConverters) - 64'd1);
  localparam logic [4:0] last_rail = 5'(NumConverters - 1);
  localparam logic [15:0] timeout = 16'(TimeoutCycles);
  localparam logic [7:0] step = 8'(StepDelayCycles);
  typedef enum logic [2:0] {IDLE, PUP_EN, PUP_WAIT, PUP_DLY, ON, PDN, FAULT} state_t;
  state_t state, nxt;
  logic [31:0] pg, en_r;
  logic [15:0] timer;
  logic [7:0] dly;
  logic [4:0] idx, top, lost_rail;
  logic lost, ext, tmo, run;
`ifdef POWER_SEQUENCER_PGOOD_DEBOUNCE_EN
  logic [31:0] s1, s2, h0, h1, h2;
  // filtered bit moves only once the newest four synchronized samples agree
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      {s1, s2, h0, h1, h2, pg} <= '0;
    end else begin
      s1 <= pgood_bus & rail_mask;
      s2 <= s1;
      h0 <= s2;
      h1 <= h0;
      h2 <= h1;
      pg <= (pg | (s2 & h0 & h1 & h2)) & (s2 | h0 | h1 | h2);
    end
`else
  assign pg = pgood_bus & rail_mask;
`endif
  assign en = en_r & rail_mask;
  always_comb begin
    run = state inside {PUP_EN, PUP_WAIT, PUP_DLY, ON};
    ext = fault_in && state != IDLE && state != FAULT;
    tmo = state == PUP_WAIT && timer == 16'd1;
    lost = 1'b0;
    lost_rail = '0;
    top = '0;
    // descending scan so the lowest failing rail is reported
    for (int i = NumConverters - 1; i >= 0; i--)
      if (!pg[i] && (state == ON || 5'(i) < idx)) begin
        lost = 1'b1;
        lost_rail = 5'(i);
      end
    for (int i = 0; i < NumConverters; i++)
      if (en_r[i]) top = 5'(i);
    case (state)
      IDLE:     nxt = start ? PUP_EN : IDLE;
      PUP_EN:   nxt = PUP_WAIT;
      PUP_WAIT: nxt = !pg[idx] ? PUP_WAIT : idx == last_rail ? ON : PUP_DLY;
      PUP_DLY:  nxt = dly == 8'd0 ? PUP_EN : PUP_DLY;
      ON:       nxt = ON;
      PDN:      nxt = dly == 8'd0 && idx == 5'd0 ? IDLE : PDN;
      FAULT:    nxt = clr_fault ? IDLE : FAULT;
      default:  nxt = IDLE;
    endcase
    if (run && stop) nxt = en_r == '0 ? IDLE : PDN;
    if ((run && lost) || tmo || ext) nxt = FAULT;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      {en_r, timer, dly, idx} <= '0;
      {busy, seq_done, seq_fault, fault_rail, fault_cause} <= '0;
    end else begin
      state <= nxt;
      busy <= nxt inside {PUP_EN, PUP_WAIT, PUP_DLY, PDN};
      seq_done <= nxt == ON;
      seq_fault <= nxt == FAULT;
      timer <= timer - 16'(timer != 16'd0);
      dly <= dly - 8'(dly != 8'd0);
      if (nxt == FAULT && state != FAULT) begin
        en_r <= '0;
        fault_rail <= ext || tmo ? idx : lost_rail;
        fault_cause <= ext ? 2'b11 : tmo ? 2'b01 : 2'b10;
      end else if (run && stop) begin
        idx <= top;
        en_r[top] <= 1'b0;
        dly <= step - 8'd1;
      end else
        case (state)
          IDLE: idx <= '0;
          PUP_EN: begin
            en_r[idx] <= 1'b1;
            timer <= timeout;
          end
          PUP_WAIT: if (nxt == PUP_DLY) dly <= step;
          PUP_DLY: if (nxt == PUP_EN) idx <= idx + 5'd1;
          PDN: if (dly == 8'd0 && idx != 5'd0) begin
            idx <= idx - 5'd1;
            en_r[idx - 5'd1] <= 1'b0;
            dly <= step - 8'd1;
          end
          FAULT: if (clr_fault) {idx, fault_rail, fault_cause} <= '0;
          default: ;
        endcase
    end
endmodule

// File: tb/tb_power_sequencer.sv
// tb_power_sequencer: scoreboard bench; pgood[i] follows en[i] ten clocks later unless masked by kill.
module tb_power_sequencer;
`ifdef POWER_SEQUENCER_PGOOD_DEBOUNCE_EN
  localparam int D = 6;
`else
  localparam int D = 0;
`endif
  logic clock = 1'b0, reset_n = 1'b1, start = 1'b0, stop = 1'b0, clr_fault = 1'b0, fault_in = 1'b0;
  logic [31:0] pgood_bus, en;
  logic busy, seq_done, seq_fault;
  logic [4:0] fault_rail;
  logic [1:0] fault_cause;
  logic [2:0] kill = 3'b000;
  logic [29:0] hist;
  int cyc = 0, base = 0, checks = 0, failures = 0;
  typedef struct {int at; string nm; logic [2:0] e; logic b, d, f; logic [4:0] r; logic [1:0] c;} exp_t;
  typedef struct {int k; logic [2:0] e; logic b, d;} vec_t;
  exp_t q[$];
  exp_t x;
  vec_t pu[8];
  event chk_now;

  power_sequencer #(.NumConverters(3), .TimeoutCycles(100), .StepDelayCycles(4)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop), .clr_fault(clr_fault),
    .fault_in(fault_in), .pgood_bus(pgood_bus), .en(en), .busy(busy), .seq_done(seq_done),
    .seq_fault(seq_fault), .fault_rail(fault_rail), .fault_cause(fault_cause)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock or negedge reset_n)
    if (!reset_n) hist <= '0;
    else hist <= {hist[26:0], en[2:0]};
  assign pgood_bus = {29'b0, hist[29:27] & ~kill};

  always begin
    @(negedge clock or chk_now);
    while (q.size() != 0 && q[0].at <= cyc) begin
      x = q.pop_front();
      checks++;
      if (x.at != cyc || en !== {29'b0, x.e} || busy !== x.b || seq_done !== x.d ||
          seq_fault !== x.f || fault_rail !== x.r || fault_cause !== x.c) begin
        failures++;
        $display("FAIL %s cyc=%0d/%0d (actual/expected) en=%h/%h busy=%b/%b done=%b/%b fault=%b/%b rail=%0d/%0d cause=%b/%b",
                 x.nm, cyc, x.at, en, x.e, busy, x.b, seq_done, x.d, seq_fault, x.f,
                 fault_rail, x.r, fault_cause, x.c);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic expect_at(input int k, input string nm, input logic [2:0] e, input logic b, d, f,
                           input logic [4:0] r, input logic [1:0] c);
    q.push_back('{base + k, nm, e, b, d, f, r, c});
  endtask

  task automatic go(input logic s, p, cf, fi);
    {start, stop, clr_fault, fault_in} = {s, p, cf, fi};
    @(negedge clock);
    {start, stop, clr_fault, fault_in} = 4'b0;
  endtask

  task automatic drain;
    while (q.size() != 0) @(negedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    kill = 3'b000;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic power_up;
    base = cyc + 1;
    foreach (pu[i]) expect_at(pu[i].k, "power_up", pu[i].e, pu[i].b, pu[i].d, 1'b0, 5'd0, 2'd0);
    go(1'b1, 1'b0, 1'b0, 1'b0);
    drain();
  endtask

  task automatic clear_fault;
    base = cyc + 1;
    expect_at(0, "clr_fault", 3'b000, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0);
    go(1'b0, 1'b0, 1'b1, 1'b0);
    drain();
  endtask

  initial begin
    pu[0] = '{0, 3'b000, 1'b1, 1'b0};
    pu[1] = '{1, 3'b001, 1'b1, 1'b0};
    pu[2] = '{17 + D, 3'b001, 1'b1, 1'b0};
    pu[3] = '{18 + D, 3'b011, 1'b1, 1'b0};
    pu[4] = '{34 + 2 * D, 3'b011, 1'b1, 1'b0};
    pu[5] = '{35 + 2 * D, 3'b111, 1'b1, 1'b0};
    pu[6] = '{45 + 3 * D, 3'b111, 1'b1, 1'b0};
    pu[7] = '{46 + 3 * D, 3'b111, 1'b0, 1'b1};
    #2 reset_n = 1'b0;
    #2 base = cyc;
    expect_at(0, "reset_state", 3'b000, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0);
    ->chk_now;
    #1;
    @(negedge clock);
    reset_n = 1'b1;
    base = cyc + 1;
    expect_at(0, "idle_ignore", 3'b000, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0);
    expect_at(3, "idle_ignore", 3'b000, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0);
    go(1'b0, 1'b1, 1'b0, 1'b1);
    drain();
    power_up();
    checks++;
    if (seq_done !== 1'b1 || busy !== 1'b0 || en !== 32'h7) begin
      failures++;
      $display("FAIL on_direct done=%b busy=%b en=%h", seq_done, busy, en);
    end
    do_reset();
    kill = 3'b010;
    base = cyc + 1;
    expect_at(1, "tmo_en0", 3'b001, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0);
    expect_at(18 + D, "tmo_en1", 3'b011, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0);
    expect_at(117 + D, "tmo_before", 3'b011, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0);
    expect_at(118 + D, "tmo_fault", 3'b000, 1'b0, 1'b0, 1'b1, 5'd1, 2'b01);
    go(1'b1, 1'b0, 1'b0, 1'b0);
    drain();
    base = cyc + 1;
    expect_at(0, "fault_start_ignored", 3'b000, 1'b0, 1'b0, 1'b1, 5'd1, 2'b01);
    expect_at(3, "fault_hold", 3'b000, 1'b0, 1'b0, 1'b1, 5'd1, 2'b01);
    go(1'b1, 1'b0, 1'b0, 1'b0);
    drain();
    clear_fault();
    checks++;
    if (seq_fault !== 1'b0 || fault_rail !== 5'd0 || fault_cause !== 2'b00 || en !== 32'h0) begin
      failures++;
      $display("FAIL clr_direct fault=%b rail=%0d cause=%b en=%h", seq_fault, fault_rail, fault_cause, en);
    end
    do_reset();
    power_up();
    base = cyc + 1;
    expect_at(D, "pgood_loss", 3'b000, 1'b0, 1'b0, 1'b1, 5'd1, 2'b10);
    kill = 3'b110;
    drain();
    kill = 3'b000;
    clear_fault();
    do_reset();
    power_up();
    base = cyc + 1;
    expect_at(0, "pdn_2", 3'b011, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0);
    expect_at(3, "pdn_2_hold", 3'b011, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0);
    expect_at(4, "pdn_1", 3'b001, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0);
    expect_at(7, "pdn_1_hold", 3'b001, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0);
    expect_at(8, "pdn_0", 3'b000, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0);
    expect_at(11, "pdn_0_hold", 3'b000, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0);
    expect_at(12, "pdn_idle", 3'b000, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0);
    go(1'b0, 1'b1, 1'b0, 1'b0);
    drain();
    checks++;
    if (en !== 32'h0 || busy !== 1'b0 || seq_done !== 1'b0) begin
      failures++;
      $display("FAIL pdn_direct en=%h busy=%b done=%b", en, busy, seq_done);
    end
    do_reset();
    power_up();
    base = cyc + 1;
    expect_at(0, "ext_over_stop", 3'b000, 1'b0, 1'b0, 1'b1, 5'd2, 2'b11);
    go(1'b0, 1'b1, 1'b0, 1'b1);
    drain();
    clear_fault();
    do_reset();
    base = cyc + 1;
    expect_at(1, "ramp_en0", 3'b001, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0);
    expect_at(6, "ramp_wait", 3'b001, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0);
    go(1'b1, 1'b0, 1'b0, 1'b0);
    drain();
    base = cyc + 1;
    expect_at(0, "ramp_stop", 3'b000, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0);
    expect_at(3, "ramp_stop_dly", 3'b000, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0);
    expect_at(4, "ramp_stop_idle", 3'b000, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0);
    go(1'b0, 1'b1, 1'b0, 1'b0);
    drain();
    do_reset();
    base = cyc + 1;
    expect_at(4, "pre_async", 3'b001, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0);
    go(1'b1, 1'b0, 1'b0, 1'b0);
    drain();
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 base = cyc;
    expect_at(0, "async_reset", 3'b000, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0);
    ->chk_now;
    #1;
    @(negedge clock);
    reset_n = 1'b1;
`ifdef POWER_SEQUENCER_PGOOD_DEBOUNCE_EN
    do_reset();
    power_up();
    base = cyc + 1;
    expect_at(5, "glitch_on", 3'b111, 1'b0, 1'b1, 1'b0, 5'd0, 2'd0);
    expect_at(10, "glitch_on", 3'b111, 1'b0, 1'b1, 1'b0, 5'd0, 2'd0);
    kill = 3'b001;
    repeat (3) @(negedge clock);
    kill = 3'b000;
    drain();
    base = cyc + 1;
    expect_at(5, "low5_pre", 3'b111, 1'b0, 1'b1, 1'b0, 5'd0, 2'd0);
    expect_at(6, "low5_fault", 3'b000, 1'b0, 1'b0, 1'b1, 5'd0, 2'b10);
    kill = 3'b001;
    repeat (5) @(negedge clock);
    kill = 3'b000;
    drain();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
